// File: rtl/owl_link_ctrl_if.sv
// rtl/owl_link_ctrl_if.sv - byte handshake between the link frame controller and the one-wire transceiver
interface owl_link_ctrl_if;
  logic       owl_wctrl;
  logic [7:0] owl_wdata;
  logic       owl_wflag;
  logic       owl_rctrl;
  logic [7:0] owl_rdata;
  logic       owl_rflag;
  logic       owl_rxsof;
  logic       owl_rxeof;
  logic       owl_rx_en;

  modport master (
    output owl_wctrl, owl_wdata, owl_rctrl, owl_rx_en,
    input  owl_wflag, owl_rdata, owl_rflag, owl_rxsof, owl_rxeof
  );

  modport slave (
    input  owl_wctrl, owl_wdata, owl_rctrl, owl_rx_en,
    output owl_wflag, owl_rdata, owl_rflag, owl_rxsof, owl_rxeof
  );
endinterface

// File: rtl/owl_link_ctrl.sv
// rtl/owl_link_ctrl.sv - one-wire link frame controller: buffered TX with checksum append, RX capture with checksum check
module owl_link_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_wr,
  input  logic [7:0]            tx_wdata,
  input  logic                  tx_go,
  output logic                  tx_full,
  output logic                  tx_busy,
  output logic                  tx_done,
  input  logic                  rx_rd,
  output logic [7:0]            rx_rdata,
  output logic                  rx_empty,
  output logic                  rx_done,
  output logic [DEPTH_LOG2:0]   rx_len,
  output logic                  rx_chk_err,
  output logic                  rx_ovf,
  owl_link_ctrl_if.master       owl
);
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_WAIT, T_CHK, T_END} tx_state_e;

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, tx_rd_q, tx_rd_d;
  logic [7:0]        tx_sum_q, tx_sum_d, wdata_q, wdata_d;
  logic              wctrl_q, wctrl_d, wflag_q, tx_done_q, tx_done_d;
  logic              tx_busy_q, tx_busy_d, tx_full_q, tx_full_d, rx_en_q, rx_en_d;
  logic              tx_we, wflag_fall;
  logic [7:0]        tx_mem_q [DEPTH];

  logic              rflag_q, rx_active_q, rx_active_d, rctrl_q, rctrl_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d, rx_rd_q, rx_rd_d, rx_len_q, rx_len_d;
  logic [7:0]        rx_sum_q, rx_sum_d;
  logic              rx_err_q, rx_err_d, rx_ovf_q, rx_ovf_d, rx_done_q, rx_done_d;
  logic              rx_empty_q, rx_empty_d, rx_we, rflag_rise;
  logic [DEPTH_LOG2-1:0] rx_waddr;
  logic [7:0]        rx_mem_q [DEPTH];

  assign wflag_fall = wflag_q & ~owl.owl_wflag;
  assign rflag_rise = owl.owl_rflag & ~rflag_q;

  always_comb begin
    state_d   = state_q;
    tx_cnt_d  = tx_cnt_q;
    tx_rd_d   = tx_rd_q;
    tx_sum_d  = tx_sum_q;
    wctrl_d   = 1'b0;
    wdata_d   = wdata_q;
    tx_done_d = 1'b0;
    // a write coinciding with tx_go is dropped so the frame length is fixed at launch
    tx_we     = tx_wr & ~tx_full_q & ~tx_go;
    if (tx_we) begin
      tx_cnt_d = tx_cnt_q + CW'(1);
      tx_sum_d = tx_sum_q + tx_wdata;
    end
    case (state_q)
      T_IDLE: if (tx_go && tx_cnt_q != '0 && !rx_active_q) state_d = T_LOAD;
      T_LOAD: begin
        wctrl_d = 1'b1;
        wdata_d = tx_mem_q[tx_rd_q[DEPTH_LOG2-1:0]];
        tx_rd_d = tx_rd_q + CW'(1);
        state_d = T_WAIT;
      end
      T_WAIT: if (wflag_fall) state_d = (tx_rd_q != tx_cnt_q) ? T_LOAD : T_CHK;
      T_CHK: begin
        wctrl_d = 1'b1;
        wdata_d = 8'h00 - tx_sum_q;
        state_d = T_END;
      end
      T_END: if (wflag_fall) begin
        tx_done_d = 1'b1;
        tx_cnt_d  = '0;
        tx_rd_d   = '0;
        tx_sum_d  = 8'h00;
        state_d   = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
    tx_busy_d = (state_d != T_IDLE);
    tx_full_d = tx_busy_d || (tx_cnt_d == DEPTH_C);
    rx_en_d   = ~tx_busy_d;
  end

  always_comb begin
    rx_active_d = rx_active_q;
    rx_cnt_d    = rx_cnt_q;
    rx_rd_d     = rx_rd_q;
    rx_sum_d    = rx_sum_q;
    rx_len_d    = rx_len_q;
    rx_err_d    = rx_err_q;
    rx_ovf_d    = rx_ovf_q;
    rx_done_d   = 1'b0;
    rctrl_d     = 1'b0;
    rx_we       = 1'b0;
    rx_waddr    = '0;
    if (rx_rd && !rx_empty_q) rx_rd_d = rx_rd_q + CW'(1);
    // ordering below gives sof-clear, then byte capture, then eof-close within one cycle
    if (owl.owl_rxsof) begin
      rx_active_d = 1'b1;
      rx_cnt_d    = '0;
      rx_rd_d     = '0;
      rx_sum_d    = 8'h00;
      rx_err_d    = 1'b0;
      rx_ovf_d    = 1'b0;
    end
    if (rflag_rise && rx_active_d) begin
      rctrl_d  = 1'b1;
      rx_sum_d = rx_sum_d + owl.owl_rdata;
      if (rx_cnt_d < DEPTH_C) begin
        rx_we    = 1'b1;
        rx_waddr = rx_cnt_d[DEPTH_LOG2-1:0];
        rx_cnt_d = rx_cnt_d + CW'(1);
      end else begin
        rx_ovf_d = 1'b1;
      end
    end
    if (owl.owl_rxeof && rx_active_d) begin
      rx_done_d   = 1'b1;
      rx_active_d = 1'b0;
      rx_len_d    = (rx_cnt_d == '0) ? '0 : rx_cnt_d - CW'(1);
      rx_err_d    = (rx_sum_d != 8'h00) || (rx_cnt_d == '0);
    end
    rx_empty_d = rx_active_d || (rx_rd_d == rx_len_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= T_IDLE;
      tx_cnt_q    <= '0;
      tx_rd_q     <= '0;
      tx_sum_q    <= 8'h00;
      wctrl_q     <= 1'b0;
      wdata_q     <= 8'h00;
      wflag_q     <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_full_q   <= 1'b0;
      rx_en_q     <= 1'b0;
      rflag_q     <= 1'b0;
      rx_active_q <= 1'b0;
      rctrl_q     <= 1'b0;
      rx_cnt_q    <= '0;
      rx_rd_q     <= '0;
      rx_len_q    <= '0;
      rx_sum_q    <= 8'h00;
      rx_err_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_empty_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_rd_q     <= tx_rd_d;
      tx_sum_q    <= tx_sum_d;
      wctrl_q     <= wctrl_d;
      wdata_q     <= wdata_d;
      wflag_q     <= owl.owl_wflag;
      tx_done_q   <= tx_done_d;
      tx_busy_q   <= tx_busy_d;
      tx_full_q   <= tx_full_d;
      rx_en_q     <= rx_en_d;
      rflag_q     <= owl.owl_rflag;
      rx_active_q <= rx_active_d;
      rctrl_q     <= rctrl_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_rd_q     <= rx_rd_d;
      rx_len_q    <= rx_len_d;
      rx_sum_q    <= rx_sum_d;
      rx_err_q    <= rx_err_d;
      rx_ovf_q    <= rx_ovf_d;
      rx_done_q   <= rx_done_d;
      rx_empty_q  <= rx_empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_we) tx_mem_q[tx_cnt_q[DEPTH_LOG2-1:0]] <= tx_wdata;
    if (rx_we) rx_mem_q[rx_waddr] <= owl.owl_rdata;
  end

  assign tx_full       = tx_full_q;
  assign tx_busy       = tx_busy_q;
  assign tx_done       = tx_done_q;
  assign rx_rdata      = rx_mem_q[rx_rd_q[DEPTH_LOG2-1:0]];
  assign rx_empty      = rx_empty_q;
  assign rx_done       = rx_done_q;
  assign rx_len        = rx_len_q;
  assign rx_chk_err    = rx_err_q;
  assign rx_ovf        = rx_ovf_q;
  assign owl.owl_wctrl = wctrl_q;
  assign owl.owl_wdata = wdata_q;
  assign owl.owl_rctrl = rctrl_q;
  assign owl.owl_rx_en = rx_en_q;
endmodule

// File: tb/tb_owl_link_ctrl.sv
// tb/tb_owl_link_ctrl.sv - randomized self-checking bench for owl_link_ctrl against a frame-level reference model
module tb_owl_link_ctrl;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  localparam int CW    = DL2 + 1;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_wr = 1'b0;
  logic [7:0]    tx_wdata = 8'h00;
  logic          tx_go = 1'b0;
  logic          tx_full, tx_busy, tx_done;
  logic          rx_rd = 1'b0;
  logic [7:0]    rx_rdata;
  logic          rx_empty, rx_done, rx_chk_err, rx_ovf;
  logic [CW-1:0] rx_len;

  int n_tests = 0;
  int n_fail  = 0;
  bq_t m_q;

  owl_link_ctrl_if owl ();

  owl_link_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_go(tx_go),
    .tx_full(tx_full), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_done(rx_done),
    .rx_len(rx_len), .rx_chk_err(rx_chk_err), .rx_ovf(rx_ovf),
    .owl(owl.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_full"}, tx_full, 0);
    check({tag, "_tx_busy"}, tx_busy, 0);
    check({tag, "_tx_done"}, tx_done, 0);
    check({tag, "_rx_empty"}, rx_empty, 1);
    check({tag, "_rx_done"}, rx_done, 0);
    check({tag, "_rx_len"}, rx_len, 0);
    check({tag, "_rx_chk_err"}, rx_chk_err, 0);
    check({tag, "_rx_ovf"}, rx_ovf, 0);
    check({tag, "_wctrl"}, owl.owl_wctrl, 0);
    check({tag, "_wdata"}, owl.owl_wdata, 0);
    check({tag, "_rctrl"}, owl.owl_rctrl, 0);
    check({tag, "_rx_en"}, owl.owl_rx_en, 0);
  endtask

  task automatic tx_write(input logic [7:0] b);
    tx_wr = 1'b1; tx_wdata = b;
    tick();
    tx_wr = 1'b0;
    if (m_q.size() < DEPTH) m_q.push_back(b);
    check("tx_full_after_wr", tx_full, m_q.size() == DEPTH);
  endtask

  task automatic tx_go_ignored(input string tag);
    tx_go = 1'b1;
    tick();
    tx_go = 1'b0;
    repeat (4) begin
      check({tag, "_no_wctrl"}, owl.owl_wctrl, 0);
      check({tag, "_not_busy"}, tx_busy, 0);
      tick();
    end
  endtask

  // Acts as the transceiver: acknowledges each strobe by holding wflag high for a random time.
  task automatic tx_send();
    bq_t exp_q, got_q;
    logic [7:0] sum, last_wd;
    int cyc, fall_cyc, hold;
    bit done_seen;
    sum = 8'h00; last_wd = 8'h00; hold = 0; done_seen = 0;
    foreach (m_q[i]) begin
      exp_q.push_back(m_q[i]);
      sum += m_q[i];
    end
    exp_q.push_back(8'h00 - sum);
    tx_go = 1'b1;
    tick();
    tx_go = 1'b0;
    cyc = 1; fall_cyc = 0;
    while (!done_seen && cyc < 400) begin
      tx_wr = 1'b0;
      if (tx_done) begin
        done_seen = 1;
        check("tx_done_after_last_byte", got_q.size(), exp_q.size());
        check("tx_done_wflag_low", owl.owl_wflag, 0);
        check("tx_busy_clear", tx_busy, 0);
        check("tx_full_clear", tx_full, 0);
        check("tx_rx_en_back", owl.owl_rx_en, 1);
      end else begin
        check("tx_busy_set", tx_busy, 1);
        check("tx_rx_en_low", owl.owl_rx_en, 0);
        if (owl.owl_wctrl) begin
          check("tx_strobe_latency", cyc - fall_cyc, 2);
          got_q.push_back(owl.owl_wdata);
          last_wd = owl.owl_wdata;
          owl.owl_wflag = 1'b1;
          hold = $urandom_range(1, 4);
        end else begin
          if (got_q.size() > 0) check("tx_wdata_hold", owl.owl_wdata, last_wd);
          if (owl.owl_wflag) begin
            hold--;
            if (hold == 0) begin
              owl.owl_wflag = 1'b0;
              fall_cyc = cyc;
            end
          end
        end
        if ($urandom_range(0, 3) == 0) begin
          tx_wr = 1'b1;
          tx_wdata = 8'($urandom);
        end
        tick();
        cyc++;
      end
    end
    tx_wr = 1'b0;
    if (!done_seen) check("tx_done_timeout", 0, 1);
    check("tx_byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("tx_byte%0d", i), got_q[i], exp_q[i]);
    m_q.delete();
    tick();
  endtask

  task automatic rx_frame(input bq_t bytes);
    int n, exp_len;
    logic [7:0] sum;
    bit merge_sof, merge_eof;
    n = bytes.size(); sum = 8'h00;
    merge_sof = (n > 0) && ($urandom_range(0, 1) == 1);
    merge_eof = (n > 0) && ($urandom_range(0, 1) == 1);
    owl.owl_rxsof = 1'b1;
    if (!merge_sof) begin
      tick();
      owl.owl_rxsof = 1'b0;
      check("rx_empty_active", rx_empty, 1);
    end
    for (int i = 0; i < n; i++) begin
      owl.owl_rdata = bytes[i];
      owl.owl_rflag = 1'b1;
      if (i == n - 1 && merge_eof) owl.owl_rxeof = 1'b1;
      sum += bytes[i];
      tick();
      owl.owl_rxsof = 1'b0;
      check("rx_rctrl_pulse", owl.owl_rctrl, 1);
      owl.owl_rflag = 1'b0;
      if (!(i == n - 1 && merge_eof)) begin
        tick();
        check("rx_rctrl_single", owl.owl_rctrl, 0);
        check("rx_empty_active", rx_empty, 1);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    if (!merge_eof) begin
      owl.owl_rxeof = 1'b1;
      tick();
    end
    owl.owl_rxeof = 1'b0;
    exp_len = (n == 0) ? 0 : ((n - 1 < DEPTH - 1) ? n - 1 : DEPTH - 1);
    check("rx_done_pulse", rx_done, 1);
    check("rx_len", rx_len, exp_len);
    check("rx_chk_err", rx_chk_err, (sum != 8'h00) || (n == 0));
    check("rx_ovf", rx_ovf, n > DEPTH);
    tick();
    check("rx_done_once", rx_done, 0);
    for (int i = 0; i < exp_len; i++) begin
      check("rx_not_empty", rx_empty, 0);
      check($sformatf("rx_rdata%0d", i), rx_rdata, bytes[i]);
      rx_rd = 1'b1;
      tick();
      rx_rd = 1'b0;
    end
    check("rx_empty_after_reads", rx_empty, 1);
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    check("rx_empty_extra_rd", rx_empty, 1);
    check("rx_len_hold", rx_len, exp_len);
  endtask

  initial begin
    bq_t fr;
    logic [7:0] s;
    int n;
    owl.owl_wflag = 1'b0; owl.owl_rdata = 8'h00; owl.owl_rflag = 1'b0;
    owl.owl_rxsof = 1'b0; owl.owl_rxeof = 1'b0;

    repeat (2) tick();
    check_reset_vals("init");
    rst = 1'b0;
    tick();
    check("rx_en_after_release", owl.owl_rx_en, 1);
    check("rx_empty_idle", rx_empty, 1);

    tx_write(8'h12); tx_write(8'h34); tx_write(8'h56);
    tx_send();

    fr = '{8'hA5, 8'h5A, 8'h01, 8'hFF}; rx_frame(fr);
    fr = '{8'h10, 8'h20, 8'h00};        rx_frame(fr);
    fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1}; rx_frame(fr);

    tx_go_ignored("go_empty");

    tx_write(8'h77); tx_write(8'h88);
    owl.owl_rxsof = 1'b1;
    tick();
    owl.owl_rxsof = 1'b0;
    tx_go_ignored("go_mid_rx");
    owl.owl_rxeof = 1'b1;
    tick();
    owl.owl_rxeof = 1'b0;
    check("empty_frame_done", rx_done, 1);
    check("empty_frame_err", rx_chk_err, 1);
    tick();
    tx_send();

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, DEPTH + 1);
        for (int i = 0; i < n; i++) tx_write(8'($urandom));
        tx_send();
      end else begin
        fr.delete();
        s = 8'h00;
        n = $urandom_range(0, 7);
        for (int i = 0; i < n; i++) begin
          fr.push_back(8'($urandom));
          s += fr[i];
        end
        if (n > 0 && $urandom_range(0, 1) == 1) fr[n-1] = 8'h00 - (s - fr[n-1]);
        rx_frame(fr);
      end
    end

    tx_write(8'hC3); tx_write(8'h3C);
    tx_go = 1'b1;
    tick();
    tx_go = 1'b0;
    tick();
    check("rst_pre_strobe", owl.owl_wctrl, 1);
    owl.owl_wflag = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check_reset_vals("mid");
    rst = 1'b0;
    owl.owl_wflag = 1'b0;
    m_q.delete();
    tick();
    check("rx_en_after_mid_rst", owl.owl_rx_en, 1);
    tx_go_ignored("go_after_rst");
    tx_write(8'h5E);
    tx_send();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
